// File: rtl/id_stage_pkg.sv
// decode_table: shared opcode/funct encodings, ALU result-select and
// operation enums, and the ID/EX latch bundle used by the decode stage.
// Contents:
//   opcode_t / funct_t : MIPS primary opcode and SPECIAL funct codes
//   alu_sel_t          : result group selected in EX
//   alu_op_t           : operation within the group
//   id_ex_t            : registered ID/EX payload
//   REG_RA             : link register index for JAL
//   rtype_op()         : SPECIAL funct -> alu_op_t
package decode_table;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_BGTZ    = 6'h07,
        OP_ADDIU   = 6'h09,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_PREF    = 6'h33
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_SRA  = 6'h03,
        FN_SLLV = 6'h04,
        FN_SRLV = 6'h06,
        FN_SRAV = 6'h07,
        FN_JR   = 6'h08,
        FN_MOVZ = 6'h0A,
        FN_MOVN = 6'h0B,
        FN_SYNC = 6'h0F,
        FN_MFHI = 6'h10,
        FN_MTHI = 6'h11,
        FN_MFLO = 6'h12,
        FN_MTLO = 6'h13,
        FN_ADDU = 6'h21,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27
    } funct_t;

    typedef enum logic [2:0] {
        RES_NOP   = 3'd0,
        RES_LOGIC = 3'd1,
        RES_SHIFT = 3'd2,
        RES_MOVE  = 3'd3,
        RES_ARITH = 3'd4,
        RES_JUMP  = 3'd5
    } alu_sel_t;

    typedef enum logic [4:0] {
        NOP_OP  = 5'd0,
        AND_OP  = 5'd1,
        OR_OP   = 5'd2,
        XOR_OP  = 5'd3,
        NOR_OP  = 5'd4,
        LUI_OP  = 5'd5,
        ADDU_OP = 5'd6,
        SLL_OP  = 5'd7,
        SRL_OP  = 5'd8,
        SRA_OP  = 5'd9,
        MFHI_OP = 5'd10,
        MFLO_OP = 5'd11,
        MTHI_OP = 5'd12,
        MTLO_OP = 5'd13,
        MOVZ_OP = 5'd14,
        MOVN_OP = 5'd15,
        J_OP    = 5'd16,
        JAL_OP  = 5'd17,
        JR_OP   = 5'd18,
        BEQ_OP  = 5'd19,
        BNE_OP  = 5'd20,
        BGTZ_OP = 5'd21
    } alu_op_t;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        alu_sel_t    sel;
        alu_op_t     op;
        logic [31:0] opnd1;
        logic [31:0] opnd2;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] link_addr;
        logic        in_delay_slot;
    } id_ex_t;

    localparam id_ex_t ID_EX_RESET = '{
        sel:           RES_NOP,
        op:            NOP_OP,
        opnd1:         32'd0,
        opnd2:         32'd0,
        we:            1'b0,
        waddr:         5'd0,
        link_addr:     32'd0,
        in_delay_slot: 1'b0
    };

    function automatic alu_op_t rtype_op(input logic [5:0] funct);
        case (funct)
            FN_AND:           return AND_OP;
            FN_OR:            return OR_OP;
            FN_XOR:           return XOR_OP;
            FN_NOR:           return NOR_OP;
            FN_ADDU:          return ADDU_OP;
            FN_SLL, FN_SLLV:  return SLL_OP;
            FN_SRL, FN_SRLV:  return SRL_OP;
            FN_SRA, FN_SRAV:  return SRA_OP;
            FN_MFHI:          return MFHI_OP;
            FN_MFLO:          return MFLO_OP;
            FN_MTHI:          return MTHI_OP;
            FN_MTLO:          return MTLO_OP;
            FN_MOVZ:          return MOVZ_OP;
            FN_MOVN:          return MOVN_OP;
            FN_JR:            return JR_OP;
            default:          return NOP_OP;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_operand_forward.sv
// operand_forward: combinational source select for one register operand.
// Ports:
//   i_addr                              : register being read
//   i_rf_data                           : register-file read data
//   i_exf_we/i_exf_waddr/i_exf_wdata    : EX-stage result
//   i_memf_we/i_memf_waddr/i_memf_wdata : MEM-stage result
//   o_data                              : resolved operand
// r0 is hard zero and never forwarded; EX is younger than MEM and wins.
module operand_forward (
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_rf_data,
    input  logic        i_exf_we,
    input  logic [4:0]  i_exf_waddr,
    input  logic [31:0] i_exf_wdata,
    input  logic        i_memf_we,
    input  logic [4:0]  i_memf_waddr,
    input  logic [31:0] i_memf_wdata,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_rf_data;
        if (i_addr == 5'd0) begin
            o_data = '0;
        end else if (i_exf_we && (i_exf_waddr == i_addr)) begin
            o_data = i_exf_wdata;
        end else if (i_memf_we && (i_memf_waddr == i_addr)) begin
            o_data = i_memf_wdata;
        end
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage.
// Ports:
//   clk, rst (sync, active-high), stall
//   id_valid, id_pc, id_inst          : instruction from the IF/ID latch
//   rf_raddr1/2, rf_rdata1/2          : register-file read (rs, rt)
//   exf_*, memf_*                     : EX / MEM forwarding sources
//   branch_taken, branch_target       : combinational redirect to IF
//   ex_sel .. ex_in_delay_slot        : registered ID/EX latch
module id_stage
    import decode_table::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_inst,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        exf_we,
    input  logic [4:0]  exf_waddr,
    input  logic [31:0] exf_wdata,
    input  logic        memf_we,
    input  logic [4:0]  memf_waddr,
    input  logic [31:0] memf_wdata,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output alu_sel_t    ex_sel,
    output alu_op_t     ex_op,
    output logic [31:0] ex_opnd1,
    output logic [31:0] ex_opnd2,
    output logic        ex_we,
    output logic [4:0]  ex_waddr,
    output logic [31:0] ex_link_addr,
    output logic        ex_in_delay_slot
);

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs, w_rt, w_rd, w_sa;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [31:0] w_a, w_b;
    logic [31:0] w_pc4, w_pc8, w_simm, w_zimm, w_br_target, w_j_target;
    id_ex_t      w_dec;
    logic        w_is_ctrl, w_cond;
    logic [31:0] w_target;

    id_ex_t      r_id_ex;
    logic        r_in_ds;

    assign w_opcode = id_inst[31:26];
    assign w_rs     = id_inst[25:21];
    assign w_rt     = id_inst[20:16];
    assign w_rd     = id_inst[15:11];
    assign w_sa     = id_inst[10:6];
    assign w_funct  = id_inst[5:0];
    assign w_imm    = id_inst[15:0];

    assign rf_raddr1 = w_rs;
    assign rf_raddr2 = w_rt;

    operand_forward u_fwd_rs (
        .i_addr       (w_rs),
        .i_rf_data    (rf_rdata1),
        .i_exf_we     (exf_we),
        .i_exf_waddr  (exf_waddr),
        .i_exf_wdata  (exf_wdata),
        .i_memf_we    (memf_we),
        .i_memf_waddr (memf_waddr),
        .i_memf_wdata (memf_wdata),
        .o_data       (w_a)
    );

    operand_forward u_fwd_rt (
        .i_addr       (w_rt),
        .i_rf_data    (rf_rdata2),
        .i_exf_we     (exf_we),
        .i_exf_waddr  (exf_waddr),
        .i_exf_wdata  (exf_wdata),
        .i_memf_we    (memf_we),
        .i_memf_waddr (memf_waddr),
        .i_memf_wdata (memf_wdata),
        .o_data       (w_b)
    );

    assign w_pc4       = id_pc + 32'd4;
    assign w_pc8       = id_pc + 32'd8;
    assign w_simm      = {{16{w_imm[15]}}, w_imm};
    assign w_zimm      = {16'd0, w_imm};
    assign w_br_target = w_pc4 + {w_simm[29:0], 2'b00};
    assign w_j_target  = {w_pc4[31:28], id_inst[25:0], 2'b00};

    always_comb begin
        w_dec     = ID_EX_RESET;
        w_is_ctrl = 1'b0;
        w_cond    = 1'b0;
        w_target  = '0;
        case (w_opcode)
            OP_SPECIAL: begin
                w_dec.op = rtype_op(w_funct);
                case (w_funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_ADDU: begin
                        w_dec.sel   = (w_funct == FN_ADDU) ? RES_ARITH : RES_LOGIC;
                        w_dec.opnd1 = w_a;
                        w_dec.opnd2 = w_b;
                        w_dec.we    = 1'b1;
                        w_dec.waddr = w_rd;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        w_dec.sel   = RES_SHIFT;
                        w_dec.opnd1 = {27'd0, w_sa};
                        w_dec.opnd2 = w_b;
                        w_dec.we    = 1'b1;
                        w_dec.waddr = w_rd;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        w_dec.sel   = RES_SHIFT;
                        w_dec.opnd1 = {27'd0, w_a[4:0]};
                        w_dec.opnd2 = w_b;
                        w_dec.we    = 1'b1;
                        w_dec.waddr = w_rd;
                    end
                    FN_MFHI, FN_MFLO: begin
                        w_dec.sel   = RES_MOVE;
                        w_dec.we    = 1'b1;
                        w_dec.waddr = w_rd;
                    end
                    FN_MTHI, FN_MTLO: begin
                        w_dec.sel   = RES_MOVE;
                        w_dec.opnd1 = w_a;
                    end
                    FN_MOVZ, FN_MOVN: begin
                        // Write enable resolves here from the forwarded rt value.
                        w_dec.sel   = RES_MOVE;
                        w_dec.opnd1 = w_a;
                        w_dec.opnd2 = w_b;
                        w_dec.waddr = w_rd;
                        w_dec.we    = (w_funct == FN_MOVN) ? (w_b != '0) : (w_b == '0);
                    end
                    FN_JR: begin
                        w_dec.sel = RES_JUMP;
                        w_is_ctrl = 1'b1;
                        w_cond    = 1'b1;
                        w_target  = w_a;
                    end
                    default: begin
                        w_dec.op = NOP_OP;
                    end
                endcase
            end
            OP_J, OP_JAL: begin
                w_dec.sel = RES_JUMP;
                w_dec.op  = (w_opcode == OP_JAL) ? JAL_OP : J_OP;
                w_is_ctrl = 1'b1;
                w_cond    = 1'b1;
                w_target  = w_j_target;
                if (w_opcode == OP_JAL) begin
                    w_dec.we        = 1'b1;
                    w_dec.waddr     = REG_RA;
                    w_dec.link_addr = w_pc8;
                end
            end
            OP_BEQ, OP_BNE, OP_BGTZ: begin
                w_dec.sel = RES_JUMP;
                w_is_ctrl = 1'b1;
                w_target  = w_br_target;
                case (w_opcode)
                    OP_BEQ: begin
                        w_dec.op = BEQ_OP;
                        w_cond   = (w_a == w_b);
                    end
                    OP_BNE: begin
                        w_dec.op = BNE_OP;
                        w_cond   = (w_a != w_b);
                    end
                    default: begin
                        w_dec.op = BGTZ_OP;
                        w_cond   = !w_a[31] && (w_a != '0);
                    end
                endcase
            end
            OP_ADDIU: begin
                w_dec.sel   = RES_ARITH;
                w_dec.op    = ADDU_OP;
                w_dec.opnd1 = w_a;
                w_dec.opnd2 = w_simm;
                w_dec.we    = 1'b1;
                w_dec.waddr = w_rt;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                w_dec.sel   = RES_LOGIC;
                w_dec.op    = (w_opcode == OP_ANDI) ? AND_OP :
                              (w_opcode == OP_ORI)  ? OR_OP  : XOR_OP;
                w_dec.opnd1 = w_a;
                w_dec.opnd2 = w_zimm;
                w_dec.we    = 1'b1;
                w_dec.waddr = w_rt;
            end
            OP_LUI: begin
                w_dec.sel   = RES_LOGIC;
                w_dec.op    = LUI_OP;
                w_dec.opnd2 = {w_imm, 16'd0};
                w_dec.we    = 1'b1;
                w_dec.waddr = w_rt;
            end
            default: begin
                w_dec.sel = RES_NOP;
            end
        endcase
        w_dec.in_delay_slot = r_in_ds;
    end

    assign branch_taken  = id_valid && !stall && w_is_ctrl && w_cond;
    assign branch_target = w_target;

    // The delay-slot flag advances only on accepted real instructions;
    // bubbles pass through without consuming the pending mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_ex <= ID_EX_RESET;
            r_in_ds <= 1'b0;
        end else if (!stall) begin
            if (id_valid) begin
                r_id_ex <= w_dec;
                r_in_ds <= w_is_ctrl;
            end else begin
                r_id_ex <= ID_EX_RESET;
            end
        end
    end

    assign ex_sel           = r_id_ex.sel;
    assign ex_op            = r_id_ex.op;
    assign ex_opnd1         = r_id_ex.opnd1;
    assign ex_opnd2         = r_id_ex.opnd2;
    assign ex_we            = r_id_ex.we;
    assign ex_waddr         = r_id_ex.waddr;
    assign ex_link_addr     = r_id_ex.link_addr;
    assign ex_in_delay_slot = r_id_ex.in_delay_slot;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios followed by randomized
// instructions, forwarding sources, stalls, bubbles and resets, all
// checked against a behavioural model of the decode stage.
module tb_id_stage;
    import decode_table::*;

    logic        clk = 1'b0;
    logic        rst, stall, id_valid;
    logic [31:0] id_pc, id_inst;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        exf_we, memf_we;
    logic [4:0]  exf_waddr, memf_waddr;
    logic [31:0] exf_wdata, memf_wdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    alu_sel_t    ex_sel;
    alu_op_t     ex_op;
    logic [31:0] ex_opnd1, ex_opnd2, ex_link_addr;
    logic        ex_we, ex_in_delay_slot;
    logic [4:0]  ex_waddr;

    logic [31:0] rf [32];

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    typedef struct {
        alu_sel_t    sel;
        alu_op_t     op;
        logic [31:0] o1, o2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] link;
        logic        ds;
    } lat_t;

    lat_t exp_q;
    logic exp_flag;

    always #5 clk = ~clk;

    // Register file model answers the bench's own rs/rt fields.
    assign rf_rdata1 = rf[id_inst[25:21]];
    assign rf_rdata2 = rf[id_inst[20:16]];

    id_stage u_dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_inst          (id_inst),
        .rf_raddr1        (rf_raddr1),
        .rf_raddr2        (rf_raddr2),
        .rf_rdata1        (rf_rdata1),
        .rf_rdata2        (rf_rdata2),
        .exf_we           (exf_we),
        .exf_waddr        (exf_waddr),
        .exf_wdata        (exf_wdata),
        .memf_we          (memf_we),
        .memf_waddr       (memf_waddr),
        .memf_wdata       (memf_wdata),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .ex_sel           (ex_sel),
        .ex_op            (ex_op),
        .ex_opnd1         (ex_opnd1),
        .ex_opnd2         (ex_opnd2),
        .ex_we            (ex_we),
        .ex_waddr         (ex_waddr),
        .ex_link_addr     (ex_link_addr),
        .ex_in_delay_slot (ex_in_delay_slot)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic lat_t bubble();
        lat_t b;
        b.sel = RES_NOP; b.op = NOP_OP; b.o1 = 0; b.o2 = 0;
        b.we = 0; b.wa = 0; b.link = 0; b.ds = 0;
        return b;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (exf_we && exf_waddr == r) return exf_wdata;
        if (memf_we && memf_waddr == r) return memf_wdata;
        return rf[r];
    endfunction

    // Reference decode of the current id_inst/id_pc from instruction fields.
    function automatic lat_t ref_decode(output logic ctrl, output logic cond, output logic [31:0] tgt);
        lat_t d;
        int unsigned opc, fn, rs, rt, rd, sa;
        logic [31:0] a, b, zimm, link_pc4;
        logic signed [31:0] simm;
        logic [31:0] inst;
        inst = id_inst;
        opc = inst[31:26]; rs = inst[25:21]; rt = inst[20:16];
        rd = inst[15:11]; sa = inst[10:6]; fn = inst[5:0];
        a = fwd(5'(rs)); b = fwd(5'(rt));
        simm = $signed(inst[15:0]);
        zimm = 32'(inst[15:0]);
        link_pc4 = id_pc + 4;
        d = bubble();
        ctrl = 0; cond = 0; tgt = 0;
        if (opc == 0) begin
            if (fn >= 'h24 && fn <= 'h27 || fn == 'h21) begin
                d.sel = (fn == 'h21) ? RES_ARITH : RES_LOGIC;
                d.op = (fn == 'h21) ? ADDU_OP : (fn == 'h24) ? AND_OP : (fn == 'h25) ? OR_OP : (fn == 'h26) ? XOR_OP : NOR_OP;
                d.o1 = a; d.o2 = b; d.we = 1; d.wa = 5'(rd);
            end else if (fn <= 7 && fn != 1 && fn != 5) begin
                d.sel = RES_SHIFT;
                d.op = (fn % 4 == 0) ? SLL_OP : (fn % 4 == 2) ? SRL_OP : SRA_OP;
                d.o1 = (fn >= 4) ? (a % 32) : 32'(sa);
                d.o2 = b; d.we = 1; d.wa = 5'(rd);
            end else if (fn >= 'h10 && fn <= 'h13) begin
                d.sel = RES_MOVE;
                d.op = (fn == 'h10) ? MFHI_OP : (fn == 'h11) ? MTHI_OP : (fn == 'h12) ? MFLO_OP : MTLO_OP;
                if (fn % 2 == 0) begin d.we = 1; d.wa = 5'(rd); end
                else d.o1 = a;
            end else if (fn == 'h0A || fn == 'h0B) begin
                d.sel = RES_MOVE; d.op = (fn == 'h0A) ? MOVZ_OP : MOVN_OP;
                d.o1 = a; d.o2 = b; d.wa = 5'(rd);
                d.we = (fn == 'h0A) ? (b == 0) : (b != 0);
            end else if (fn == 'h08) begin
                d.sel = RES_JUMP; d.op = JR_OP;
                ctrl = 1; cond = 1; tgt = a;
            end
        end else if (opc == 2 || opc == 3) begin
            d.sel = RES_JUMP; d.op = (opc == 3) ? JAL_OP : J_OP;
            ctrl = 1; cond = 1;
            tgt = (link_pc4 & 32'hF000_0000) | (32'(inst[25:0]) * 4);
            if (opc == 3) begin d.we = 1; d.wa = 31; d.link = id_pc + 8; end
        end else if (opc == 4 || opc == 5 || opc == 7) begin
            d.sel = RES_JUMP; ctrl = 1;
            tgt = link_pc4 + simm * 4;
            if (opc == 4) begin d.op = BEQ_OP; cond = (a == b); end
            else if (opc == 5) begin d.op = BNE_OP; cond = (a != b); end
            else begin d.op = BGTZ_OP; cond = ($signed(a) > 0); end
        end else if (opc == 9) begin
            d.sel = RES_ARITH; d.op = ADDU_OP; d.o1 = a; d.o2 = simm; d.we = 1; d.wa = 5'(rt);
        end else if (opc >= 'h0C && opc <= 'h0E) begin
            d.sel = RES_LOGIC; d.op = (opc == 'h0C) ? AND_OP : (opc == 'h0D) ? OR_OP : XOR_OP;
            d.o1 = a; d.o2 = zimm; d.we = 1; d.wa = 5'(rt);
        end else if (opc == 'h0F) begin
            d.sel = RES_LOGIC; d.op = LUI_OP; d.o2 = zimm * 65536; d.we = 1; d.wa = 5'(rt);
        end
        return d;
    endfunction

    // One clock: check combinational outputs, advance model, check latch.
    task automatic run_cycle();
        lat_t d;
        logic c, cnd;
        logic [31:0] t;
        #1;
        d = ref_decode(c, cnd, t);
        check_eq("raddr1", 32'(rf_raddr1), 32'(id_inst[25:21]));
        check_eq("raddr2", 32'(rf_raddr2), 32'(id_inst[20:16]));
        check_eq("branch_taken", 32'(branch_taken), 32'(id_valid && !stall && c && cnd));
        check_eq("branch_target", branch_target, t);
        @(posedge clk);
        if (rst) begin
            exp_q = bubble(); exp_flag = 0;
        end else if (!stall) begin
            if (id_valid) begin
                d.ds = exp_flag; exp_q = d; exp_flag = c;
            end else begin
                exp_q = bubble();
            end
        end
        #1;
        check_eq("ex_sel", 32'(ex_sel), 32'(exp_q.sel));
        check_eq("ex_op", 32'(ex_op), 32'(exp_q.op));
        check_eq("ex_opnd1", ex_opnd1, exp_q.o1);
        check_eq("ex_opnd2", ex_opnd2, exp_q.o2);
        check_eq("ex_we", 32'(ex_we), 32'(exp_q.we));
        check_eq("ex_waddr", 32'(ex_waddr), 32'(exp_q.wa));
        check_eq("ex_link_addr", ex_link_addr, exp_q.link);
        check_eq("ex_in_delay_slot", 32'(ex_in_delay_slot), 32'(exp_q.ds));
        @(negedge clk);
    endtask

    task automatic set_fw(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                          input logic mw, input logic [4:0] ma, input logic [31:0] md);
        exf_we = ew; exf_waddr = ea; exf_wdata = ed;
        memf_we = mw; memf_waddr = ma; memf_wdata = md;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0] rs, rt, rd, sa;
        logic [15:0] imm;
        logic [5:0] fn;
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) rt = rs;
        rd = 5'($urandom); sa = 5'($urandom); imm = 16'($urandom);
        case ($urandom_range(0, 19))
            0: return {6'h0D, rs, rt, imm};
            1: return {6'h0C, rs, rt, imm};
            2: return {6'h0E, rs, rt, imm};
            3: return {6'h09, rs, rt, imm};
            4: return {6'h0F, rs, rt, imm};
            5: return {6'h04, rs, rt, imm};
            6: return {6'h05, rs, rt, imm};
            7: return {6'h07, rs, rt, imm};
            8: return {6'h02, 26'($urandom)};
            9: return {6'h03, 26'($urandom)};
            10: return {6'h33, 26'($urandom)};
            11: return $urandom;
            default: begin
                case ($urandom_range(0, 19))
                    0: fn = 6'h00;  1: fn = 6'h02;  2: fn = 6'h03;  3: fn = 6'h04;
                    4: fn = 6'h06;  5: fn = 6'h07;  6: fn = 6'h08;  7: fn = 6'h0A;
                    8: fn = 6'h0B;  9: fn = 6'h0F;  10: fn = 6'h10; 11: fn = 6'h11;
                    12: fn = 6'h12; 13: fn = 6'h13; 14: fn = 6'h21; 15: fn = 6'h24;
                    16: fn = 6'h25; 17: fn = 6'h26; 18: fn = 6'h27;
                    default: fn = 6'($urandom);
                endcase
                return {6'h00, rs, rt, rd, sa, fn};
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_data();
        if ($urandom_range(0, 3) == 0) return 32'd0;
        return $urandom;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        rst = 1; stall = 0; id_valid = 1; id_pc = 0; id_inst = {6'h0D, 5'd1, 5'd2, 16'h1234};
        set_fw(0, 0, 0, 0, 0, 0);
        exp_q = bubble(); exp_flag = 0;
        @(negedge clk);

        // Reset state
        run_cycle();
        run_cycle();
        check_eq("rst_sel", 32'(ex_sel), 32'(RES_NOP));
        check_eq("rst_we", 32'(ex_we), 32'd0);
        rst = 0;

        // Immediate extension
        id_pc = 32'h40; id_inst = {6'h0D, 5'd0, 5'd1, 16'h8001};
        run_cycle();
        check_eq("ori_op", 32'(ex_op), 32'(OR_OP));
        check_eq("ori_imm", ex_opnd2, 32'h0000_8001);
        check_eq("ori_waddr", 32'(ex_waddr), 32'd1);
        check_eq("ori_we", 32'(ex_we), 32'd1);
        id_inst = {6'h09, 5'd0, 5'd1, 16'h8001};
        run_cycle();
        check_eq("addiu_imm", ex_opnd2, 32'hFFFF_8001);

        // Forwarding priority
        rf[2] = 32'h1111;
        set_fw(1, 5'd2, 32'hAAAA, 1, 5'd2, 32'h5555);
        id_inst = {6'h0D, 5'd2, 5'd3, 16'h0000};
        run_cycle();
        check_eq("fwd_ex", ex_opnd1, 32'hAAAA);
        exf_waddr = 5'd3;
        run_cycle();
        check_eq("fwd_mem", ex_opnd1, 32'h5555);
        set_fw(1, 5'd0, 32'h7777, 1, 5'd0, 32'h6666);
        id_inst = {6'h0D, 5'd0, 5'd3, 16'h0000};
        run_cycle();
        check_eq("fwd_r0", ex_opnd1, 32'h0);
        set_fw(0, 0, 0, 0, 0, 0);

        // Branch and delay slot
        rf[5] = 32'h1234;
        id_pc = 32'h100; id_inst = {6'h04, 5'd5, 5'd5, 16'd4};
        #1;
        check_eq("beq_taken", 32'(branch_taken), 32'd1);
        check_eq("beq_target", branch_target, 32'h114);
        run_cycle();
        id_valid = 0;
        run_cycle();
        id_valid = 1; id_pc = 32'h104; id_inst = {6'h0D, 5'd0, 5'd1, 16'h0001};
        run_cycle();
        check_eq("ds_set", 32'(ex_in_delay_slot), 32'd1);
        id_pc = 32'h108;
        run_cycle();
        check_eq("ds_clear", 32'(ex_in_delay_slot), 32'd0);

        // JAL link
        id_pc = 32'h200; id_inst = {6'h03, 26'h40};
        run_cycle();
        check_eq("jal_waddr", 32'(ex_waddr), 32'd31);
        check_eq("jal_link", ex_link_addr, 32'h208);
        check_eq("jal_sel", 32'(ex_sel), 32'(RES_JUMP));

        // MOVZ with forwarded rt
        rf[6] = 32'h99;
        set_fw(1, 5'd6, 32'd0, 0, 0, 0);
        id_inst = {6'h00, 5'd1, 5'd6, 5'd4, 5'd0, 6'h0A};
        run_cycle();
        check_eq("movz_zero", 32'(ex_we), 32'd1);
        exf_wdata = 32'd7;
        run_cycle();
        check_eq("movz_nz", 32'(ex_we), 32'd0);
        set_fw(0, 0, 0, 0, 0, 0);

        // Stall hold, then reset during stall
        id_inst = {6'h0D, 5'd0, 5'd9, 16'hBEEF};
        run_cycle();
        stall = 1; id_pc = 32'h300; id_inst = {6'h04, 5'd5, 5'd5, 16'd8};
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check_eq("stall_taken", 32'(branch_taken), 32'd0);
            check_eq("stall_hold", ex_opnd2, 32'h0000_BEEF);
        end
        rst = 1;
        run_cycle();
        check_eq("rst_stall_we", 32'(ex_we), 32'd0);
        check_eq("rst_stall_op2", ex_opnd2, 32'd0);
        rst = 0; stall = 0;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 49) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            id_valid = ($urandom_range(0, 6) != 0);
            id_pc    = $urandom & 32'hFFFF_FFFC;
            id_inst  = rand_inst();
            rf[$urandom_range(0, 31)] = rand_data();
            set_fw(1'($urandom), 5'($urandom_range(0, 7)), rand_data(),
                   1'($urandom), 5'($urandom_range(0, 7)), rand_data());
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage MIPS pipeline, between the IF/ID latch and the execute stage. Decodes one 32-bit instruction per cycle into the shared `alu_sel_t`/`alu_op_t` encoding, reads the register file with EX/MEM forwarding, and resolves branches and jumps in ID. Results go to a registered ID/EX latch with stall hold and bubble insertion. It also tracks branch-delay-slot status.

## Interface
- No parameters; widths fixed at 32-bit data, 5-bit register addresses.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold ID/EX latch and delay-slot flag.
- `id_valid` in 1: `id_inst` is a real instruction; 0 means bubble.
- `id_pc` in 32: PC of `id_inst`.
- `id_inst` in 32: instruction word.
- `rf_raddr1`, `rf_raddr2` out 5: comb read addresses (rs, rt).
- `rf_rdata1`, `rf_rdata2` in 32: comb read data.
- `exf_we`, `exf_waddr`, `exf_wdata` in 1/5/32: EX-stage result for forwarding.
- `memf_we`, `memf_waddr`, `memf_wdata` in 1/5/32: MEM-stage result for forwarding.
- `branch_taken` out 1: comb redirect request to IF.
- `branch_target` out 32: comb redirect PC.
- `ex_sel` out `alu_sel_t`: registered.
- `ex_op` out `alu_op_t`: registered.
- `ex_opnd1`, `ex_opnd2` out 32: registered operands.
- `ex_we`, `ex_waddr` out 1/5: registered writeback control.
- `ex_link_addr` out 32: registered return address.
- `ex_in_delay_slot` out 1: registered delay-slot marker.

## Operation
- Operand fetch: r0 reads 0. Otherwise use EX forward if `exf_we` and address match, else MEM forward if match, else `rf_rdata`. EX has priority over MEM.
- Immediates:
  - ANDI/ORI/XORI zero-extend imm16.
  - ADDIU sign-extends imm16.
  - LUI gives {imm16, 16'b0} as opnd2 with `LUI_OP`.
  - Immediate ops write rt.
- R-type: sel/op per funct. The logic group and ADDU write rd.
- Shifts: SLL/SRL/SRA put sa in opnd1 and rt in opnd2. SLLV/SRLV/SRAV put rs[4:0] zero-extended in opnd1.
- MFHI/MFLO write rd. MTHI/MTLO have `ex_we`=0 and pass rs.
- MOVN/MOVZ: `ex_we` = (rt≠0) for MOVN, (rt==0) for MOVZ, using forwarded rt. opnd1 = rs.
- Branches (BEQ, BNE, BGTZ signed >0): target = pc+4 + (sext(imm16)<<2).
- J/JAL: target = {pc+4[31:28], idx26, 2'b00}.
- R_JR: target = forwarded rs.
- JAL: `ex_sel`=RES_JUMP, `ex_op`=JAL_OP, `ex_we`=1, `ex_waddr`=31, `ex_link_addr`=pc+8.
- Other control transfers: `ex_we`=0, sel RES_JUMP.
- SYNC, PREF and unknown opcode/funct decode as RES_NOP/NOP_OP with `ex_we`=0. No exception is raised.
- `branch_taken` = `id_valid` & !`stall` & condition.
- Delay-slot flag: set when a branch/jump is accepted (`id_valid` & !`stall`), whether taken or not. Cleared when the next valid instruction is accepted. That instruction carries `ex_in_delay_slot`=1.

## Timing
- Decode, forwarding and branch resolution are combinational within one cycle. ID/EX outputs appear one edge later.
- `rst`: all `ex_*` go to 0, `ex_sel`=RES_NOP, `ex_op`=NOP_OP, delay-slot flag cleared. Reset overrides `stall`. Reset mid-branch drops the pending delay-slot mark.
- `stall`=1: the ID/EX latch and the flag hold, and `branch_taken`=0.
- `stall`=0 with `id_valid`=0: a bubble (reset values) is latched and the flag is unchanged.
- Simultaneous EX and MEM match on the same register: EX data is used.
- A forward to r0 is ignored.

## Structure
- Add to package `decode_table`:
  - `id_ex_t` struct bundling the registered outputs.
  - Constant `REG_RA` = 5'd31.
  - Existing opcode, funct and ALU enums reused.
- One sub-module, `operand_forward`: a comb mux taking (addr, rf_data, exf_*, memf_*) and producing data. Instantiated twice.
- The top module holds the decoder, branch unit, delay-slot flop and ID/EX latch.

## Test plan
- ORI r1,r0,0x8001 → `ex_op`=OR_OP, opnd2=0x00008001, `ex_waddr`=1, `ex_we`=1. ADDIU imm 0x8001 → opnd2=0xFFFF8001.
- rs=2 with `exf_wdata`=0xAAAA, `memf_wdata`=0x5555 and rf=0x1111 → opnd1=0xAAAA. With EX not matching → 0x5555.
- BEQ equal at pc=0x100, imm=4 → `branch_taken`=1, target=0x114. The next valid instruction has `ex_in_delay_slot`=1; the following one has 0.
- JAL at pc=0x200 → `ex_waddr`=31, `ex_link_addr`=0x208, `ex_sel`=RES_JUMP.
- MOVZ with rt forwarded as 0 → `ex_we`=1. With rt=7 → `ex_we`=0.
- `stall` for 3 cycles → outputs held and `branch_taken`=0. `rst` asserted during a stall → outputs go to reset values next edge.
